// File: rtl/control_seq_pkg.sv
// Shared types and constants for the WF8 control sequencer and its opcode decoder.
package control_seq_pkg;

   typedef enum logic [2:0] {
      CS_IDLE   = 3'd0,
      CS_FETCH  = 3'd1,
      CS_DECODE = 3'd2,
      CS_EXEC   = 3'd3,
      CS_MEM    = 3'd4,
      CS_WB     = 3'd5,
      CS_FAULT  = 3'd6
   } cs_state_t;

   localparam int ALU_MODE_COUNT = 7;

   localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_ADD      = 7'b000_0001;
   localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_SHIFT    = 7'b000_0010;
   localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_NOT      = 7'b000_0100;
   localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_AND      = 7'b000_1000;
   localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_OR       = 7'b001_0000;
   localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_XOR      = 7'b010_0000;
   localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_BYPASS_A = 7'b100_0000;

   // Opcode classes are opcode[4:1]; bit 0 only distinguishes variants.
   localparam logic [3:0] OPC_ADD    = 4'b0000;
   localparam logic [3:0] OPC_ADDI   = 4'b0001;
   localparam logic [3:0] OPC_SH     = 4'b0010;
   localparam logic [3:0] OPC_SHI    = 4'b0011;
   localparam logic [3:0] OPC_NOT    = 4'b0100;
   localparam logic [3:0] OPC_AND    = 4'b0101;
   localparam logic [3:0] OPC_OR     = 4'b0110;
   localparam logic [3:0] OPC_XOR    = 4'b0111;
   localparam logic [3:0] OPC_CPY    = 4'b1000;
   localparam logic [3:0] OPC_LB     = 4'b1001;
   localparam logic [3:0] OPC_SB     = 4'b1010;
   localparam logic [3:0] OPC_JMPADR = 4'b1011;
   localparam logic [3:0] OPC_JMPI   = 4'b1100;
   localparam logic [3:0] OPC_BRL    = 4'b1101;
   localparam logic [3:0] OPC_BRE    = 4'b1110;

   localparam int CTRL_MEM_TIMEOUT = 15;

   typedef struct packed {
      logic [ALU_MODE_COUNT-1:0] alu_mode;
      logic                      rd;
      logic                      wr;
      logic                      a_sel;
      logic                      b_sel;
      logic                      is_mem;
      logic                      is_store;
      logic                      is_jump;
      logic                      is_branch;
      logic                      illegal;
   } dec_t;

endpackage

// File: rtl/control_dec.sv
// Combinational opcode classifier: maps the 5-bit opcode onto datapath controls
// and instruction-class flags used by the sequencer.
module control_dec
   import control_seq_pkg::*;
(
   input  logic [4:0] opcode,
   output dec_t       ctl
);

   always_comb begin
      ctl          = '0;
      ctl.alu_mode = ALU_MODE_ADD;
      case (opcode[4:1])
         OPC_ADD:    begin ctl.rd = 1'b1; ctl.wr = 1'b1; end
         OPC_ADDI:   begin ctl.wr = 1'b1; ctl.b_sel = 1'b1; end
         OPC_SH:     begin ctl.alu_mode = ALU_MODE_SHIFT; ctl.rd = 1'b1; ctl.wr = 1'b1; end
         OPC_SHI:    begin ctl.alu_mode = ALU_MODE_SHIFT; ctl.wr = 1'b1; ctl.b_sel = 1'b1; end
         OPC_NOT:    begin ctl.alu_mode = ALU_MODE_NOT; ctl.wr = 1'b1; end
         OPC_AND:    begin ctl.alu_mode = ALU_MODE_AND; ctl.rd = 1'b1; ctl.wr = 1'b1; end
         OPC_OR:     begin ctl.alu_mode = ALU_MODE_OR;  ctl.rd = 1'b1; ctl.wr = 1'b1; end
         OPC_XOR:    begin ctl.alu_mode = ALU_MODE_XOR; ctl.rd = 1'b1; ctl.wr = 1'b1; end
         OPC_CPY: begin
            // op[0] selects cpypc: copy the PC instead of reg_b.
            ctl.alu_mode = ALU_MODE_BYPASS_A;
            ctl.wr       = 1'b1;
            ctl.rd       = ~opcode[0];
            ctl.a_sel    = opcode[0];
         end
         OPC_LB:     begin ctl.alu_mode = ALU_MODE_BYPASS_A; ctl.wr = 1'b1; ctl.is_mem = 1'b1; end
         OPC_SB: begin
            ctl.alu_mode = ALU_MODE_BYPASS_A;
            ctl.rd       = 1'b1;
            ctl.is_mem   = 1'b1;
            ctl.is_store = 1'b1;
         end
         OPC_JMPADR: begin ctl.alu_mode = ALU_MODE_BYPASS_A; ctl.rd = 1'b1; ctl.is_jump = 1'b1; end
         OPC_JMPI:   begin ctl.a_sel = 1'b1; ctl.b_sel = 1'b1; ctl.is_jump = 1'b1; end
         OPC_BRL,
         OPC_BRE:    begin ctl.a_sel = 1'b1; ctl.b_sel = 1'b1; ctl.is_branch = 1'b1; end
         default:    ctl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_seq.sv
// Multi-cycle WF8 control sequencer: instruction register, memory handshakes
// with a timeout watchdog, and per-phase datapath/PC control.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CS_IDLE   | stopped; leaves when run=1
// CS_FETCH  | imem_req high, waiting for imem_ready (watchdog running)
// CS_DECODE | classify ir; illegal opcode faults
// CS_EXEC   | datapath settles; lb/sb go to MEM
// CS_MEM    | dmem_req high, waiting for dmem_ready (watchdog running)
// CS_WB     | register write, PC update, retire; run picks FETCH or IDLE
// CS_FAULT  | sticky fault until reset
module control_seq
   import control_seq_pkg::*;
#(
   parameter int INSTR_W     = 8,
   parameter int MEM_TIMEOUT = CTRL_MEM_TIMEOUT,
   parameter int TMO_W       = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      run,
   output logic                      imem_req,
   input  logic                      imem_ready,
   input  logic [INSTR_W-1:0]        imem_rdata,
   output logic                      dmem_req,
   output logic                      dmem_we,
   input  logic                      dmem_ready,
   input  logic                      branch_cond,
   output logic [4:0]                ir_opcode,
   output logic [INSTR_W-6:0]        ir_reg,
   output logic [ALU_MODE_COUNT-1:0] alu_mode,
   output logic                      alu_a_sel,
   output logic                      alu_b_sel,
   output logic                      reg_b_read_en,
   output logic                      reg_b_write_en,
   output logic                      pc_inc,
   output logic                      pc_load,
   output logic                      retire,
   output logic                      fault
);

   cs_state_t          state, state_nxt;
   logic [INSTR_W-1:0] ir;
   logic               ir_load;
   logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
   logic               tmo_hit;
   logic               dp_active;
   dec_t               ctl;

   control_dec u_dec (
      .opcode (ir[INSTR_W-1 -: 5]),
      .ctl    (ctl)
   );

   assign ir_opcode = ir[INSTR_W-1 -: 5];
   assign ir_reg    = ir[INSTR_W-6:0];

   // The count equals the number of waiting cycles already spent, so the
   // MEM_TIMEOUT-th cycle is the last one on which ready is still accepted.
   assign tmo_hit   = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
   assign dp_active = (state == CS_DECODE) || (state == CS_EXEC) ||
                      (state == CS_MEM)    || (state == CS_WB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CS_IDLE;
         ir      <= '0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_nxt;
         if (ir_load) ir <= imem_rdata;
      end
   end

   always_comb begin
      state_nxt      = state;
      tmo_nxt        = tmo_cnt;
      ir_load        = 1'b0;
      imem_req       = 1'b0;
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      reg_b_write_en = 1'b0;
      pc_inc         = 1'b0;
      pc_load        = 1'b0;
      retire         = 1'b0;
      fault          = 1'b0;
      alu_mode       = dp_active ? ctl.alu_mode : ALU_MODE_ADD;
      alu_a_sel      = dp_active & ctl.a_sel;
      alu_b_sel      = dp_active & ctl.b_sel;
      reg_b_read_en  = dp_active & ctl.rd;

      case (state)
         CS_IDLE: begin
            if (run) begin
               state_nxt = CS_FETCH;
               tmo_nxt   = '0;
            end
         end
         CS_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_load   = 1'b1;
               state_nxt = CS_DECODE;
            end else if (tmo_hit) begin
               state_nxt = CS_FAULT;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         CS_DECODE: state_nxt = ctl.illegal ? CS_FAULT : CS_EXEC;
         CS_EXEC: begin
            if (ctl.is_mem) begin
               state_nxt = CS_MEM;
               tmo_nxt   = '0;
            end else begin
               state_nxt = CS_WB;
            end
         end
         CS_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = ctl.is_store;
            if (dmem_ready) begin
               state_nxt = CS_WB;
            end else if (tmo_hit) begin
               state_nxt = CS_FAULT;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         CS_WB: begin
            retire         = 1'b1;
            reg_b_write_en = ctl.wr;
            pc_load        = ctl.is_jump | (ctl.is_branch & branch_cond);
            pc_inc         = ~pc_load;
            if (run) begin
               state_nxt = CS_FETCH;
               tmo_nxt   = '0;
            end else begin
               state_nxt = CS_IDLE;
            end
         end
         CS_FAULT: fault = 1'b1;
         default:  state_nxt = CS_FAULT;
      endcase
   end

endmodule

// File: tb/tb_control_seq.sv
// Randomized bench for control_seq: builds an expected per-cycle trace from an
// instruction-level model, then replays the stimulus and compares every cycle.
module tb_control_seq;
   import control_seq_pkg::*;

   localparam int TMO = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       imem_req;
   logic       imem_ready = 1'b0;
   logic [7:0] imem_rdata = '0;
   logic       dmem_req;
   logic       dmem_we;
   logic       dmem_ready = 1'b0;
   logic       branch_cond = 1'b0;
   logic [4:0] ir_opcode;
   logic [2:0] ir_reg;
   logic [6:0] alu_mode;
   logic       alu_a_sel, alu_b_sel, reg_b_read_en, reg_b_write_en;
   logic       pc_inc, pc_load, retire, fault;

   control_seq #(.INSTR_W(8), .MEM_TIMEOUT(TMO), .TMO_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .branch_cond(branch_cond), .ir_opcode(ir_opcode), .ir_reg(ir_reg),
      .alu_mode(alu_mode), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
      .reg_b_read_en(reg_b_read_en), .reg_b_write_en(reg_b_write_en),
      .pc_inc(pc_inc), .pc_load(pc_load), .retire(retire), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       imem_ready;
      logic [7:0] rdata;
      logic       dmem_ready;
      logic       bc;
      logic       run;
   } stim_t;

   typedef struct packed {
      logic [6:0] mode;
      logic rd, wr, as, bs, mem, st, jmp, br, ill;
   } ref_t;

   stim_t       sq[$];
   logic [25:0] eq[$];
   string       tq[$];
   logic [7:0]  cur_ir = '0;
   int          n_test = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [25:0] got, input logic [25:0] exp);
      n_test++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [25:0] obs();
      return {imem_req, dmem_req, dmem_we, alu_mode, alu_a_sel, alu_b_sel,
              reg_b_read_en, reg_b_write_en, pc_inc, pc_load, retire, fault,
              ir_opcode, ir_reg};
   endfunction

   function automatic logic [25:0] mk(logic ireq, logic dreq, logic we, logic [6:0] mode,
                                      logic as, logic bs, logic rd, logic wr,
                                      logic inc, logic ld, logic ret, logic flt);
      return {ireq, dreq, we, mode, as, bs, rd, wr, inc, ld, ret, flt, cur_ir};
   endfunction

   // Instruction semantics from the opcode map, expressed as class sets.
   function automatic ref_t ref_ctl(logic [4:0] op);
      ref_t r;
      int   c;
      c      = int'(op[4:1]);
      r      = '0;
      r.mode = ALU_MODE_ADD;
      if (c == 15) begin
         r.ill = 1'b1;
         return r;
      end
      case (c)
         2, 3:        r.mode = ALU_MODE_SHIFT;
         4:           r.mode = ALU_MODE_NOT;
         5:           r.mode = ALU_MODE_AND;
         6:           r.mode = ALU_MODE_OR;
         7:           r.mode = ALU_MODE_XOR;
         8, 9, 10, 11: r.mode = ALU_MODE_BYPASS_A;
         default:     r.mode = ALU_MODE_ADD;
      endcase
      r.rd  = (c inside {0, 2, 5, 6, 7, 10, 11}) || (c == 8 && !op[0]);
      r.wr  = (c <= 9);
      r.as  = (c == 8 && op[0]) || (c >= 12);
      r.bs  = c inside {1, 3, 12, 13, 14};
      r.mem = c inside {9, 10};
      r.st  = (c == 10);
      r.jmp = c inside {11, 12};
      r.br  = c inside {13, 14};
      return r;
   endfunction

   task automatic push(input logic ir_rdy, input logic [7:0] rd, input logic dr,
                       input logic bc, input logic rn, input logic [25:0] e, input string t);
      stim_t s;
      s = '{imem_ready: ir_rdy, rdata: rd, dmem_ready: dr, bc: bc, run: rn};
      sq.push_back(s);
      eq.push_back(e);
      tq.push_back(t);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_idle(input logic rn);
      push(rb(), 8'($urandom), rb(), rb(), rn,
           mk(0, 0, 0, ALU_MODE_ADD, 0, 0, 0, 0, 0, 0, 0, 0), "idle");
   endtask

   task automatic push_fault(input int n);
      for (int i = 0; i < n; i++)
         push(rb(), 8'($urandom), rb(), rb(), rb(),
              mk(0, 0, 0, ALU_MODE_ADD, 0, 0, 0, 0, 0, 0, 0, 1), "fault");
   endtask

   // Expected trace of one instruction; ilat/dlat are wait cycles before ready.
   task automatic gen_instr(input logic [7:0] instr, input int ilat, input int dlat,
                            input logic bc, input logic run_after, input int idle_n);
      ref_t r;
      logic ld;
      r = ref_ctl(instr[7:3]);
      if (ilat >= TMO) begin
         for (int i = 0; i < TMO; i++)
            push(1'b0, 8'($urandom), rb(), rb(), rb(),
                 mk(1, 0, 0, ALU_MODE_ADD, 0, 0, 0, 0, 0, 0, 0, 0), "fetch");
         return;
      end
      for (int i = 0; i <= ilat; i++)
         push(i == ilat, (i == ilat) ? instr : 8'($urandom), rb(), rb(), rb(),
              mk(1, 0, 0, ALU_MODE_ADD, 0, 0, 0, 0, 0, 0, 0, 0), "fetch");
      cur_ir = instr;
      push(rb(), 8'($urandom), rb(), rb(), rb(),
           mk(0, 0, 0, r.mode, r.as, r.bs, r.rd, 0, 0, 0, 0, 0), "decode");
      if (r.ill) return;
      push(rb(), 8'($urandom), rb(), rb(), rb(),
           mk(0, 0, 0, r.mode, r.as, r.bs, r.rd, 0, 0, 0, 0, 0), "exec");
      if (r.mem) begin
         for (int j = 0; j < TMO && j <= dlat; j++)
            push(rb(), 8'($urandom), j == dlat, rb(), rb(),
                 mk(0, 1, r.st, r.mode, r.as, r.bs, r.rd, 0, 0, 0, 0, 0), "mem");
         if (dlat >= TMO) return;
      end
      ld = r.jmp | (r.br & bc);
      push(rb(), 8'($urandom), rb(), bc, run_after,
           mk(0, 0, 0, r.mode, r.as, r.bs, r.rd, r.wr, !ld, ld, 1, 0), "wb");
      if (!run_after) begin
         for (int k = 0; k < idle_n; k++) push_idle(1'b0);
         push_idle(1'b1);
      end
   endtask

   // Replays up to n queued cycles, then drops any leftover trace.
   task automatic play(input int n);
      stim_t       s;
      logic [25:0] e;
      string       t;
      int          left;
      left = n;
      while (sq.size() > 0 && left > 0) begin
         s = sq.pop_front();
         e = eq.pop_front();
         t = tq.pop_front();
         imem_ready  = s.imem_ready;
         imem_rdata  = s.rdata;
         dmem_ready  = s.dmem_ready;
         branch_cond = s.bc;
         run         = s.run;
         @(negedge clk);
         chk(t, obs(), e);
         @(posedge clk);
         #1;
         left--;
      end
      sq.delete();
      eq.delete();
      tq.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      cur_ir = '0;
      chk("reset", obs(), mk(0, 0, 0, ALU_MODE_ADD, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] rand_legal();
      logic [3:0] c;
      c = 4'($urandom_range(0, 14));
      return {c, rb(), 3'($urandom)};
   endfunction

   function automatic int rand_lat();
      return ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 3);
   endfunction

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // add x0 with immediate fetch, then lb with 3-cycle data wait
      push_idle(1'b1);
      gen_instr(8'h00, 0, 0, 1'b0, 1'b1, 0);
      gen_instr(8'b10010_011, 0, 3, 1'b0, 1'b1, 0);
      // sb, taken beq, not-taken bneq
      gen_instr(8'b10100_101, 1, 0, 1'b0, 1'b1, 0);
      gen_instr(8'b11100_010, 0, 0, 1'b1, 1'b1, 0);
      gen_instr(8'b11101_001, 2, 0, 1'b0, 1'b0, 2);
      // ready on the last allowed cycle is accepted
      gen_instr(8'b10010_111, TMO - 1, TMO - 1, 1'b0, 1'b1, 0);
      for (int i = 0; i < 40; i++)
         gen_instr(rand_legal(), rand_lat(), rand_lat(), rb(),
                   ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
      // illegal opcode faults from DECODE and stays there
      gen_instr(8'b11110_000, 0, 0, 1'b0, 1'b1, 0);
      push_fault(6);
      play(100000);

      // fetch watchdog
      do_reset();
      push_idle(1'b1);
      gen_instr(8'h00, TMO, 0, 1'b0, 1'b1, 0);
      push_fault(6);
      play(100000);

      // data watchdog
      do_reset();
      push_idle(1'b1);
      gen_instr(8'b10100_000, 0, TMO, 1'b0, 1'b1, 0);
      push_fault(4);
      play(100000);

      // reset in the middle of a data access
      do_reset();
      push_idle(1'b1);
      gen_instr(8'b10010_001, 1, 10, 1'b0, 1'b1, 0);
      play(1 + 2 + 2 + 2);
      chk("mem_before_rst", {31'b0, dmem_req}, 32'd1);
      do_reset();
      for (int k = 0; k < 3; k++) push_idle(1'b0);
      push_idle(1'b1);
      gen_instr(rand_legal(), 1, 1, 1'b1, 1'b0, 0);
      play(100000);

      $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
      $finish;
   end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Multi-cycle, parametrised control sequencer for the WF8 core. Successor to the purely combinational opcode decoder.
- Owns the fetch/decode/execute/memory/writeback FSM and the instruction register.
- Handles ready/req handshakes to instruction and data memory, with a timeout watchdog and illegal-opcode detection.
- Drives the same datapath controls (alu_mode, reg_b enables, alu_a_sel/alu_b_sel, memory write), plus PC control.

Parameters:
- INSTR_W, 8, instruction width; opcode = ir[INSTR_W-1 -: 5], reg field = ir[INSTR_W-6:0]; INSTR_W >= 6.
- MEM_TIMEOUT, 15, max cycles waiting for any *_ready before fault; 1..2^TMO_W-1.
- TMO_W, 4, timeout counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  enable; sampled only in FETCH entry
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- dmem_req  out  1  data access request (lb/sb)
- dmem_we  out  1  data write (sb), valid with dmem_req
- dmem_ready  in  1  data access complete
- branch_cond  in  1  comparator result for current branch
- ir_opcode  out  5  latched opcode
- ir_reg  out  INSTR_W-5  latched register/imm field
- alu_mode  out  `ALU_MODE_COUNT  one-hot ALU mode
- alu_a_sel  out  1  0 accumulator, 1 PC
- alu_b_sel  out  1  0 register, 1 immediate
- reg_b_read_en  out  1  reg_b drives cpu_bus
- reg_b_write_en  out  1  reg_b written (WB pulse)
- pc_inc  out  1  PC += 1 (WB pulse)
- pc_load  out  1  PC <= ALU result (WB pulse, taken jump/branch)
- retire  out  1  one-cycle pulse per completed instruction
- fault  out  1  sticky fault flag

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT. 3-bit state encoding.
- Reset (async): state=IDLE, ir=0, timeout counter=0. All outputs 0, except alu_mode = `ALU_MODE_ADD`.
- IDLE: if run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1 while in FETCH.
  - On imem_ready=1: ir<=imem_rdata, go to DECODE.
- DECODE (1 cycle): classify opcode[4:1]. Encoding 1111 is illegal -> FAULT. Otherwise -> EXEC.
- Opcode map (opcode[4:1] -> alu_mode; reg_b_read_en; reg_b_write_en; alu_a_sel; alu_b_sel):
  - 0000 add -> ADD; rd; wr; 0; 0
  - 0001 addi -> ADD; -; wr; 0; 1
  - 0010 sh -> SHIFT; rd; wr; 0; 0
  - 0011 shi -> SHIFT; -; wr; 0; 1
  - 0100 not -> NOT; -; wr
  - 0101 and -> AND; rd; wr
  - 0110 or -> OR; rd; wr
  - 0111 xor -> XOR; rd; wr
  - 1000 cpy (op[0]=0) -> BYPASS_A; rd; wr; 0
  - 1000 cpypc (op[0]=1) -> BYPASS_A; -; wr; a_sel=1
  - 1001 lb -> BYPASS_A; -; wr
  - 1010 sb -> BYPASS_A; rd; -
  - 1011 jmpadr -> BYPASS_A; rd; -
  - 1100 jmpi -> ADD; a_sel=1; b_sel=1
  - 1101 blt/bge -> ADD; a_sel=1; b_sel=1
  - 1110 beq/bneq -> ADD; a_sel=1; b_sel=1
- EXEC (1 cycle): alu_mode, alu_a_sel, alu_b_sel and reg_b_read_en are driven from DECODE onward through WB. lb/sb -> MEM; all others -> WB.
- MEM:
  - dmem_req=1; dmem_we=1 for sb only.
  - On dmem_ready -> WB.
- WB (1 cycle):
  - reg_b_write_en pulses for write-class ops.
  - pc_load=1 for jmpadr, jmpi, and branches with branch_cond=1 (branch_cond sampled in WB).
  - Otherwise pc_inc=1.
  - retire=1.
  - Next state: FETCH if run=1, else IDLE.
- Timeout:
  - Counter clears on entering FETCH or MEM and increments each waiting cycle.
  - If it reaches MEM_TIMEOUT without ready -> FAULT.
  - ready on the MEM_TIMEOUT-th cycle is still accepted.
- FAULT:
  - fault=1; all enables and reqs 0.
  - Held until rst_n low; run is ignored.
- Ready asserted while req=0 is ignored.
- Reset mid-transaction aborts immediately; reqs drop asynchronously.
- Exactly one of pc_inc/pc_load per retire; never both.

Decomposition:
- param.vh gains:
  - `ALU_MODE_XOR`, and `ALU_MODE_COUNT` updated to include XOR.
  - State encodings `CS_IDLE`..`CS_FAULT`.
  - Opcode-class constants `OPC_ADD`..`OPC_BRE` (4-bit).
  - `CTRL_MEM_TIMEOUT` default.
- Sub-module control_dec: purely combinational opcode[4:0] -> {alu_mode, rd, wr, a_sel, b_sel, is_mem, is_jump, is_branch, illegal}.
- control_seq holds only the FSM, ir and timeout counter.

Test Plan:
- run=1, imem returns 0x00 (add x0) with ready on 1st request cycle -> states IDLE,FETCH,DECODE,EXEC,WB; reg_b_write_en and pc_inc pulse in WB; retire after 4 cycles from FETCH.
- lb (opcode 10010), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, single reg_b_write_en in WB.
- sb (10100) then beq with branch_cond=1 then bneq with branch_cond=0 -> dmem_we=1 for sb; pc_load for beq; pc_inc for bneq; no reg_b_write_en.
- imem_ready held low, MEM_TIMEOUT=15 -> FAULT on 16th FETCH cycle; fault sticky; run toggling has no effect until rst_n pulse.
- Opcode 11110 -> FAULT from DECODE, no write or PC pulse.
- rst_n low during MEM -> all outputs to reset values the same cycle; after release, IDLE.
